alu_share_arbiter: RTL

- Shares one combinational ALU instance (3-bit function select, three 32-bit operands, one 32-bit result) between two requesters.
- Each requester issues commands {func, a, b, c} over a valid/ready handshake.
- The block arbitrates round-robin, drives the ALU from a held operand register, and captures the result into an output register.
- It returns the result with a requester ID over a valid/ready response channel. It sits between PE-local control logic and the shared ALU.

---
 rtl/alu_share_pkg.sv | 19 +
 rtl/alu_share_arbiter_rr_arb2.sv | 27 ++
 rtl/alu_share_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/alu_share_pkg.sv
// Shared types and defaults for the two-requester ALU sharing arbiter.
package alu_share_pkg;

    localparam int unsigned ALU_DATA_W   = 32;
    localparam int unsigned ALU_FUNC_W   = 3;
    localparam int unsigned ALU_NUM_FUNC = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Function codes at or above num_func are rejected with an error response.
    function automatic logic is_legal_func(input logic [31:0] func, input int unsigned num_func);
        return func < num_func;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the last-granted pointer moves only on advance.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       gnt_id,
    output logic       any
);

    logic last_q;

    // On contention the requester that did not win last time is granted.
    always_comb begin
        any    = |req;
        gnt_id = (&req) ? ~last_q : req[1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (advance && any) begin
            last_q <= gnt_id;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters with round-robin grant
// and a valid/ready response channel carrying the requester ID.
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int unsigned DATA_W   = ALU_DATA_W,
    parameter int unsigned FUNC_W   = ALU_FUNC_W,
    parameter int unsigned NUM_FUNC = ALU_NUM_FUNC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [FUNC_W-1:0] req0_func,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [DATA_W-1:0] req0_c,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [FUNC_W-1:0] req1_func,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [DATA_W-1:0] req1_c,
    output logic [FUNC_W-1:0] alu_func,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [DATA_W-1:0] alu_in3,
    input  logic [DATA_W-1:0] alu_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_id,
    output logic              rsp_err,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [FUNC_W-1:0] alu_func_q, alu_func_d;
    logic [DATA_W-1:0] alu_in1_q, alu_in1_d;
    logic [DATA_W-1:0] alu_in2_q, alu_in2_d;
    logic [DATA_W-1:0] alu_in3_q, alu_in3_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_id_q, rsp_id_d;
    logic              rsp_err_q, rsp_err_d;
    logic              id_q, id_d;

    logic              gnt_id;
    logic              any_req;
    logic              accept_win;
    logic              accept;
    logic              legal;
    logic [FUNC_W-1:0] sel_func;
    logic [DATA_W-1:0] sel_a, sel_b, sel_c;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({req1_valid, req0_valid}),
        .advance (accept),
        .gnt_id  (gnt_id),
        .any     (any_req)
    );

    // A new command can be taken when idle, or while the current response is consumed.
    always_comb begin
        accept_win = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
        accept     = accept_win && any_req;
        req0_ready = accept && !gnt_id;
        req1_ready = accept && gnt_id;
        sel_func   = gnt_id ? req1_func : req0_func;
        sel_a      = gnt_id ? req1_a    : req0_a;
        sel_b      = gnt_id ? req1_b    : req0_b;
        sel_c      = gnt_id ? req1_c    : req0_c;
        legal      = is_legal_func(32'(sel_func), NUM_FUNC);
    end

    always_comb begin
        state_d    = state_q;
        alu_func_d = alu_func_q;
        alu_in1_d  = alu_in1_q;
        alu_in2_d  = alu_in2_q;
        alu_in3_d  = alu_in3_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        rsp_err_d  = rsp_err_q;
        id_d       = id_q;

        case (state_q)
            EXEC: begin
                rsp_data_d = alu_out;
                rsp_err_d  = 1'b0;
                rsp_id_d   = id_q;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
            end
        endcase

        // Illegal commands bypass the ALU and respond directly with an error.
        if (accept) begin
            if (legal) begin
                alu_func_d = sel_func;
                alu_in1_d  = sel_a;
                alu_in2_d  = sel_b;
                alu_in3_d  = sel_c;
                id_d       = gnt_id;
                state_d    = EXEC;
            end else begin
                rsp_data_d = '0;
                rsp_err_d  = 1'b1;
                rsp_id_d   = gnt_id;
                state_d    = RESP;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            alu_func_q <= '0;
            alu_in1_q  <= '0;
            alu_in2_q  <= '0;
            alu_in3_q  <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= 1'b0;
            rsp_err_q  <= 1'b0;
            id_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_func_q <= alu_func_d;
            alu_in1_q  <= alu_in1_d;
            alu_in2_q  <= alu_in2_d;
            alu_in3_q  <= alu_in3_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
            rsp_err_q  <= rsp_err_d;
            id_q       <= id_d;
        end
    end

    always_comb begin
        alu_func  = alu_func_q;
        alu_in1   = alu_in1_q;
        alu_in2   = alu_in2_q;
        alu_in3   = alu_in3_q;
        rsp_data  = rsp_data_q;
        rsp_id    = rsp_id_q;
        rsp_err   = rsp_err_q;
        rsp_valid = (state_q == RESP);
        busy      = (state_q != IDLE);
    end

endmodule
